sync_fifo_prog: RTL and testbench
=================================

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The module SHALL have parameter FIFO_WIDTH, default 16: data word width in bits, legal range 1..64.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8: number of entries, legal range 2..1024, not restricted to powers of two.
REQ-003 The module SHALL have parameter AF_MARGIN, default 1: almostfull threshold distance from full, legal range 1..FIFO_DEPTH-1.
REQ-004 The module SHALL have parameter AE_MARGIN, default 1: almostempty threshold distance from empty, legal range 1..FIFO_DEPTH-1.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port wr_en, input, 1 bit: write request.
REQ-008 Port rd_en, input, 1 bit: read request.
REQ-009 Port data_in, input, FIFO_WIDTH bits: write data.
REQ-010 Port data_out, output, FIFO_WIDTH bits: registered read data.
REQ-011 Port wr_ack, output, 1 bit: registered, asserted when the previous cycle's write was accepted.
REQ-012 Port overflow, output, 1 bit: registered, asserted when the previous cycle's write was rejected.
REQ-013 Port underflow, output, 1 bit: registered, asserted when the previous cycle's read was rejected.
REQ-014 Port full, output, 1 bit: combinational, count==FIFO_DEPTH.
REQ-015 Port empty, output, 1 bit: combinational, count==0.
REQ-016 Port almostfull, output, 1 bit: combinational, FIFO_DEPTH-AF_MARGIN <= count < FIFO_DEPTH.
REQ-017 Port almostempty, output, 1 bit: combinational, 0 < count <= AE_MARGIN.
REQ-018 Port count, output, $clog2(FIFO_DEPTH+1) bits: current occupancy.

Function
REQ-019 Write acceptance: a write SHALL be accepted iff wr_en && !full.
- Accepted write stores data_in at mem[wr_ptr].
- wr_en && rd_en while full: read only; write rejected.
REQ-020 Read acceptance: a read SHALL be accepted iff rd_en && !empty.
- Accepted read loads data_out <= mem[rd_ptr] at the same edge; latency is 1 cycle.
- data_out holds its value when no read is accepted.
- wr_en && rd_en while empty: write only; read rejected.
REQ-021 Pointer wrap: wr_ptr and rd_ptr SHALL each increment by 1 per accepted operation and wrap from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH.
REQ-022 Count update: count SHALL change by +1 (write only), -1 (read only), or 0 (both accepted, or neither); count never exceeds FIFO_DEPTH and never underflows.
REQ-023 Registered flags: wr_ack, overflow and underflow SHALL each be valid for exactly one cycle after the request cycle, not sticky.
- overflow = wr_en && full in the request cycle.
- underflow = rd_en && empty in the request cycle.

Reset
REQ-024 While rst_n=0, the following SHALL be cleared immediately, independent of clk: wr_ptr, rd_ptr, count, wr_ack, overflow, underflow, data_out. Resulting outputs: empty=1, full=0, almostfull=0, almostempty=0.
REQ-025 Reset asserted mid-operation SHALL discard all stored data; memory contents need not be cleared.
REQ-026 The first accepted write after rst_n rises SHALL land at entry 0.

Configuration
REQ-027 When macro SYNC_FIFO_PROG_ASSERT_EN is defined, the module SHALL compile in concurrent assertions and covers, disabled while rst_n=0, checking:
- flag/count consistency (full, empty, almostfull, almostempty vs count);
- pointer increment and wrap;
- count delta for each wr_en/rd_en/full/empty combination;
- overflow and underflow one cycle after the rejected request.
REQ-028 Without SYNC_FIFO_PROG_ASSERT_EN, no assertion or cover code SHALL be elaborated, and functional behaviour SHALL be identical.

Structure
REQ-029 Package sync_fifo_prog_pkg SHALL hold the parameter defaults and a function computing the pointer/count widths.
REQ-030 Storage SHALL be a sub-module sync_fifo_prog_mem: FIFO_DEPTH x FIFO_WIDTH array, one write port, one registered read port.

Verification
REQ-031 Defaults: reset, then write 8 words 0x0001..0x0008 -> wr_ack each cycle after; count 8; full=1; almostfull=0 at count 8, almostfull=1 at count 7.
REQ-032 Full, then wr_en with data_in=0xDEAD -> overflow=1 next cycle; count stays 8; 0xDEAD is never read out.
REQ-033 Empty, then rd_en=1 -> underflow=1 next cycle; count 0; data_out unchanged.
REQ-034 Full, then wr_en=rd_en=1 -> count 7, data_out=0x0001, overflow=1. Empty, then wr_en=rd_en=1 -> count 1, underflow=1.
REQ-035 FIFO_DEPTH=5, AF_MARGIN=2, AE_MARGIN=2: 12 write/read pairs -> pointers wrap 4->0; data returned in order; almostempty at count 1..2; almostfull at count 3..4.
REQ-036 Assert rst_n=0 mid-burst at count 4 -> same cycle: count 0, empty=1, all registered flags 0; next write after release is read back first.

Source files
------------

// File: rtl/sync_fifo_prog_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_prog_pkg
// Shared definitions for the programmable-threshold synchronous FIFO:
// parameter defaults, the per-cycle operation encoding and width helpers.
// Ports: none (package).
// ----------------------------------------------------------------------------
package sync_fifo_prog_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_AF_MARGIN  = 1;
  localparam int DEF_AE_MARGIN  = 1;

  // Accepted-operation pair for one cycle: {write accepted, read accepted}
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Pointer width: enough to address entries 0..depth-1, never below 1 bit
  function automatic int calc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: must represent 0..depth inclusive
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_prog_if
// Bus bundle between a FIFO user (master) and the FIFO (slave).
// Signals: wr_en, rd_en, data_in (master -> FIFO);
//          data_out, wr_ack, overflow, underflow, full, empty,
//          almostfull, almostempty, count (FIFO -> master).
// ----------------------------------------------------------------------------
interface sync_fifo_prog_if
  import sync_fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  localparam int CNT_W = calc_cnt_w(FIFO_DEPTH);

  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/sync_fifo_prog_mem.sv
// ----------------------------------------------------------------------------
// sync_fifo_prog_mem
// FIFO_DEPTH x FIFO_WIDTH storage with one write port and one registered
// read port. The array itself is not reset; only the read register is.
// Ports: clk, rst_n, i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
//        o_rd_data (registered, holds when i_rd_en is low).
// ----------------------------------------------------------------------------
module sync_fifo_prog_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [FIFO_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [FIFO_WIDTH-1:0] o_rd_data
);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] r_rd_data;

  // Write port: storage carries no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port: loads only on an accepted read, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= {FIFO_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_prog.sv
// ----------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with programmable almost-full / almost-empty margins and
// any depth (pointers wrap explicitly at FIFO_DEPTH-1).
// Ports: clk, rst_n (async active-low), bus (sync_fifo_prog_if.slave).
//   wr_ack/overflow/underflow/data_out are registered; full, empty,
//   almostfull, almostempty are decoded combinationally from count.
// Optional build macro: SYNC_FIFO_PROG_ASSERT_EN compiles in concurrent
// assertions and covers on flags, pointers, count and error flags.
// ----------------------------------------------------------------------------
module sync_fifo_prog
  import sync_fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN,
  parameter int AE_MARGIN  = DEF_AE_MARGIN
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int PTR_W = calc_ptr_w(FIFO_DEPTH);
  localparam int CNT_W = calc_cnt_w(FIFO_DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_wr_ack;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  fifo_op_e         w_op;

  // Wrap at FIFO_DEPTH-1 rather than relying on binary rollover
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
  endfunction

  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == {CNT_W{1'b0}});
  // Full blocks the write even when a read frees a slot in the same cycle
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;
  assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});

  // Pointers, occupancy and one-cycle status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= bus.rd_en & w_empty;
      r_wr_ptr    <= w_wr_acc ? ptr_inc(r_wr_ptr) : r_wr_ptr;
      r_rd_ptr    <= w_rd_acc ? ptr_inc(r_rd_ptr) : r_rd_ptr;
      case (w_op)
        OP_WRITE: r_count <= r_count + CNT_W'(1);
        OP_READ:  r_count <= r_count - CNT_W'(1);
        default:  r_count <= r_count;
      endcase
    end
  end

  sync_fifo_prog_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (bus.data_out)
  );

  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostfull  = ~w_full & (r_count >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
  assign bus.almostempty = ~w_empty & (r_count <= CNT_W'(AE_MARGIN));
  assign bus.wr_ack      = r_wr_ack;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

`ifdef SYNC_FIFO_PROG_ASSERT_EN
  a_full_flag: assert property (@(posedge clk) disable iff (!rst_n)
    bus.full == (r_count == CNT_W'(FIFO_DEPTH)));
  a_empty_flag: assert property (@(posedge clk) disable iff (!rst_n)
    bus.empty == (r_count == {CNT_W{1'b0}}));
  a_af_flag: assert property (@(posedge clk) disable iff (!rst_n)
    bus.almostfull == ((r_count >= CNT_W'(FIFO_DEPTH - AF_MARGIN)) && (r_count < CNT_W'(FIFO_DEPTH))));
  a_ae_flag: assert property (@(posedge clk) disable iff (!rst_n)
    bus.almostempty == ((r_count > {CNT_W{1'b0}}) && (r_count <= CNT_W'(AE_MARGIN))));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(FIFO_DEPTH));
  a_wr_ptr_inc: assert property (@(posedge clk) disable iff (!rst_n)
    w_wr_acc |=> (r_wr_ptr == ptr_inc($past(r_wr_ptr))));
  a_wr_ptr_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !w_wr_acc |=> $stable(r_wr_ptr));
  a_rd_ptr_inc: assert property (@(posedge clk) disable iff (!rst_n)
    w_rd_acc |=> (r_rd_ptr == ptr_inc($past(r_rd_ptr))));
  a_rd_ptr_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !w_rd_acc |=> $stable(r_rd_ptr));
  a_cnt_up: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wr_en && !w_full && !(bus.rd_en && !w_empty)) |=> (r_count == $past(r_count) + CNT_W'(1)));
  a_cnt_down: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_en && !w_empty && !(bus.wr_en && !w_full)) |=> (r_count == $past(r_count) - CNT_W'(1)));
  a_cnt_same: assert property (@(posedge clk) disable iff (!rst_n)
    ((w_op == OP_BOTH) || (w_op == OP_IDLE)) |=> $stable(r_count));
  a_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wr_en && w_full) |=> bus.overflow);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.wr_en && w_full) |=> !bus.overflow);
  a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_en && w_empty) |=> bus.underflow);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.rd_en && w_empty) |=> !bus.underflow);
  c_wr_wrap: cover property (@(posedge clk) disable iff (!rst_n)
    w_wr_acc && (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)));
  c_rd_wrap: cover property (@(posedge clk) disable iff (!rst_n)
    w_rd_acc && (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)));
  c_both_full: cover property (@(posedge clk) disable iff (!rst_n)
    bus.wr_en && bus.rd_en && w_full);
  c_both_empty: cover property (@(posedge clk) disable iff (!rst_n)
    bus.wr_en && bus.rd_en && w_empty);
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_prog
// Drives two FIFO instances (depth 8 / margins 1,1 and depth 5 / margins 2,2)
// in lockstep with the same stimulus and compares every output after each
// clock edge against a queue-based reference model per instance.
// ----------------------------------------------------------------------------
module tb_sync_fifo_prog;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if_d8 ();
  sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if_d5 ();

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) dut_d8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d8)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2)) dut_d5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d5)
  );

  // Reference model: a queue of stored words plus the expected registered outputs
  int unsigned m_depth [2] = '{8, 5};
  int unsigned m_af    [2] = '{1, 2};
  int unsigned m_ae    [2] = '{1, 2};
  logic [15:0] m_q     [2][$];
  logic [15:0] m_dout  [2];
  logic        m_ack   [2];
  logic        m_ovf   [2];
  logic        m_udf   [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k].delete();
      m_dout[k] = 16'h0000;
      m_ack[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      m_udf[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic we, input logic re, input logic [15:0] din);
    int unsigned sz;
    logic        wacc;
    logic        racc;
    sz       = m_q[k].size();
    wacc     = we && (sz < m_depth[k]);
    racc     = re && (sz > 0);
    m_ack[k] = wacc;
    m_ovf[k] = we && (sz == m_depth[k]);
    m_udf[k] = re && (sz == 0);
    if (racc) m_dout[k] = m_q[k].pop_front();
    if (wacc) m_q[k].push_back(din);
  endtask

  task automatic check_inst(input int k);
    int unsigned sz;
    string       p;
    logic [63:0] o_cnt, o_full, o_empty, o_af, o_ae, o_ack, o_ovf, o_udf, o_dout;
    sz = m_q[k].size();
    if (k == 0) begin
      p = "d8";
      o_cnt = 64'(if_d8.count);      o_full = 64'(if_d8.full);      o_empty = 64'(if_d8.empty);
      o_af  = 64'(if_d8.almostfull); o_ae   = 64'(if_d8.almostempty);
      o_ack = 64'(if_d8.wr_ack);     o_ovf  = 64'(if_d8.overflow);  o_udf   = 64'(if_d8.underflow);
      o_dout = 64'(if_d8.data_out);
    end else begin
      p = "d5";
      o_cnt = 64'(if_d5.count);      o_full = 64'(if_d5.full);      o_empty = 64'(if_d5.empty);
      o_af  = 64'(if_d5.almostfull); o_ae   = 64'(if_d5.almostempty);
      o_ack = 64'(if_d5.wr_ack);     o_ovf  = 64'(if_d5.overflow);  o_udf   = 64'(if_d5.underflow);
      o_dout = 64'(if_d5.data_out);
    end
    check_val({p, ".count"},       o_cnt,   64'(sz));
    check_val({p, ".full"},        o_full,  64'(sz == m_depth[k]));
    check_val({p, ".empty"},       o_empty, 64'(sz == 0));
    check_val({p, ".almostfull"},  o_af,    64'((sz >= m_depth[k] - m_af[k]) && (sz < m_depth[k])));
    check_val({p, ".almostempty"}, o_ae,    64'((sz > 0) && (sz <= m_ae[k])));
    check_val({p, ".wr_ack"},      o_ack,   64'(m_ack[k]));
    check_val({p, ".overflow"},    o_ovf,   64'(m_ovf[k]));
    check_val({p, ".underflow"},   o_udf,   64'(m_udf[k]));
    check_val({p, ".data_out"},    o_dout,  64'(m_dout[k]));
  endtask

  // One clock: drive inputs, step the model at the edge, check #1 later
  task automatic cycle(input logic we, input logic re, input logic [15:0] din);
    if_d8.wr_en = we; if_d8.rd_en = re; if_d8.data_in = din;
    if_d5.wr_en = we; if_d5.rd_en = re; if_d5.data_in = din;
    @(posedge clk);
    model_step(0, we, re, din);
    model_step(1, we, re, din);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  initial begin
    int bias;
    if_d8.wr_en = 1'b0; if_d8.rd_en = 1'b0; if_d8.data_in = 16'h0000;
    if_d5.wr_en = 1'b0; if_d5.rd_en = 1'b0; if_d5.data_in = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 1..8; depth-5 instance overflows on the last three
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 16'(i));
    check_val("d8.fill_count", 64'(if_d8.count), 64'd8);
    check_val("d8.fill_full",  64'(if_d8.full),  64'd1);
    check_val("d8.fill_af",    64'(if_d8.almostfull), 64'd0);

    // Write while full is rejected
    cycle(1'b1, 1'b0, 16'hDEAD);
    check_val("d8.ovf_when_full", 64'(if_d8.overflow), 64'd1);
    check_val("d8.ovf_count",     64'(if_d8.count),    64'd8);

    // Write+read while full: read only
    cycle(1'b1, 1'b1, 16'h0BAD);
    check_val("d8.both_full_count", 64'(if_d8.count),    64'd7);
    check_val("d8.both_full_dout",  64'(if_d8.data_out), 64'h1);
    check_val("d8.both_full_ovf",   64'(if_d8.overflow), 64'd1);

    // Drain past empty; data_out must hold the last word (8, never 0xDEAD)
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h0000);
    check_val("d8.udf_when_empty", 64'(if_d8.underflow), 64'd1);
    check_val("d8.udf_dout_hold",  64'(if_d8.data_out),  64'h8);
    check_val("d8.udf_count",      64'(if_d8.count),     64'd0);

    // Write+read while empty: write only
    cycle(1'b1, 1'b1, 16'h00A5);
    check_val("d8.both_empty_count", 64'(if_d8.count),     64'd1);
    check_val("d8.both_empty_udf",   64'(if_d8.underflow), 64'd1);
    cycle(1'b0, 1'b1, 16'h0000);
    check_val("d8.both_empty_word",  64'(if_d8.data_out),  64'h00A5);

    // Write/read pairs walk both pointers around the depth-5 ring
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 16'($urandom));
      cycle(1'b0, 1'b1, 16'h0000);
    end

    // Random traffic with alternating bias to reach both full and empty
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      cycle(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
            16'($urandom));
    end

    // Mid-burst reset at count 4
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'(16'h0100 + i));
    check_val("d8.pre_reset_count", 64'(if_d8.count), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    check_val("d8.reset_empty", 64'(if_d8.empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 16'h5A5A);
    cycle(1'b0, 1'b1, 16'h0000);
    check_val("d8.first_after_reset", 64'(if_d8.data_out), 64'h5A5A);
    check_val("d5.first_after_reset", 64'(if_d5.data_out), 64'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
